branch_issuer: RTL and testbench
================================

Name: branch_issuer

Overview:
- Command-side driver for the program-counter brancher. It owns the brancher's enable/strobe/flag/branch inputs and watches the brancher's program counter and ready outputs.
- Loop: fetch a 24-bit control word at the current PC, decode it, issue one strobed command to the brancher, wait for ready, repeat.
- Sits between instruction memory and the brancher in the sequencer path.

Parameters:
- FETCH_TIMEOUT, 16, cycles allowed from fetch request to rx_fetch_valid before FAULT; minimum 2.
- RESET_PC, 16'h0000, fetch address used for the first fetch after reset or after rx_run rises.

Ports:
- aclk  input  1  clock, all logic on rising edge
- aresetn  input  1  asynchronous active-low reset
- rx_run  input  1  level; 1 = sequencing allowed
- rx_alu_flags  input  4  live condition flags, sampled on SETF issue
- rx_program_counter  input  16  PC from brancher
- rx_ready  input  1  brancher ready
- rx_fetch_valid  input  1  fetch data valid, single-cycle pulse
- rx_fetch_data  input  24  control word
- tx_fetch_req  output  1  fetch request, held until valid
- tx_fetch_addr  output  16  fetch address
- tx_enable  output  1  brancher enable
- tx_write_branch  output  1  brancher branch-write select
- tx_write_flags  output  1  brancher flag-write select
- tx_strobe  output  1  one-cycle command pulse
- tx_input_flags  output  4  flags to load
- tx_check_flags  output  4  condition mask for branch
- tx_branch  output  16  branch target
- tx_fault  output  1  fetch-timeout fault, sticky

Behaviour:
- Reset (aresetn=0, asynchronous): state IDLE, every output 0, timeout counter 0, next-fetch address RESET_PC.
- Control word decode, op=[23:22]:
  - 00 NOP: strobe with write_branch=0 and write_flags=0, so the PC advances.
  - 01 SETF: write_flags=1; tx_input_flags = rx_alu_flags sampled in the ISSUE cycle.
  - 10 BRC: write_branch=1; check_flags=[19:16]; branch=[15:0].
  - 11 JMP: same as BRC but check_flags forced to 4'b0000.
  - Bits [21:20] are ignored.
- tx_enable = 1 in every state except IDLE and FAULT (registered).
- IDLE: when rx_run=1, go to FETCH with address RESET_PC.
- FETCH:
  - tx_fetch_req=1 and tx_fetch_addr stable; counter increments every cycle.
  - rx_fetch_valid=1: latch data, drop req the next cycle, go to ISSUE.
  - Counter reaches FETCH_TIMEOUT with no valid: go to FAULT.
  - A valid arriving in the same cycle as the timeout wins; no fault.
- ISSUE:
  - Wait until rx_ready=1.
  - In that cycle assert tx_strobe for exactly 1 cycle. Select and data fields become valid in the same cycle and stay held until the next ISSUE.
  - Then go to WAIT.
- WAIT:
  - rx_ready is ignored in the first cycle after the strobe, so the brancher's stale ready cannot be taken as completion.
  - From the second cycle on, rx_ready=1: next fetch address = rx_program_counter, go to FETCH.
  - Issue-to-next-fetch_req latency is 2 cycles minimum.
- rx_run=0: go to IDLE at the next safe point.
  - In FETCH: abort immediately, drop req, discard any later valid.
  - In ISSUE before the strobe: abort with no strobe.
  - In WAIT: finish the wait, then go to IDLE instead of FETCH.
  - The next run restarts at RESET_PC.
- FAULT:
  - tx_fault=1, tx_enable=0, no strobes.
  - Leave only by reset, or by rx_run falling to 0, which clears the fault and goes to IDLE.
- rx_fetch_valid outside FETCH is ignored.
- Reset mid-command drops tx_strobe and tx_fetch_req to 0 immediately (asynchronous).

Test Plan:
- Reset then rx_run=1 with the memory answering in 3 cycles -> tx_fetch_addr=16'h0000; when rx_ready=1, tx_strobe pulses 1 cycle; all select bits 0 for NOP word 24'h000000.
- Word 24'h8A1234 (BRC) -> tx_write_branch=1, tx_check_flags=4'hA, tx_branch=16'h1234. With rx_program_counter=16'h1234 at ready, the next tx_fetch_addr=16'h1234.
- Word 24'h400000 (SETF) with rx_alu_flags=4'b0101 during ISSUE -> tx_write_flags=1, tx_input_flags=4'b0101. Word 24'hCF00FF (JMP) -> tx_check_flags=0, tx_branch=16'h00FF.
- rx_ready held 1 continuously -> exactly one strobe per command, and no fetch in the cycle right after the strobe.
- No rx_fetch_valid for 16 cycles -> tx_fault=1, tx_enable=0. Valid on cycle 16 instead -> no fault. Drop rx_run -> fault clears, state IDLE.
- rx_run=0 mid-FETCH, then a late valid -> no strobe; the next run fetches 16'h0000. aresetn pulsed mid-ISSUE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_issuer.sv
// Sequencer front end for the PC brancher: fetches a control word at the current PC,
// decodes it, issues one strobed command, waits for completion, and repeats.
module branch_issuer #(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter logic [15:0] RESET_PC      = 16'h0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        rx_run,
  input  logic [3:0]  rx_alu_flags,
  input  logic [15:0] rx_program_counter,
  input  logic        rx_ready,
  input  logic        rx_fetch_valid,
  input  logic [23:0] rx_fetch_data,
  output logic        tx_fetch_req,
  output logic [15:0] tx_fetch_addr,
  output logic        tx_enable,
  output logic        tx_write_branch,
  output logic        tx_write_flags,
  output logic        tx_strobe,
  output logic [3:0]  tx_input_flags,
  output logic [3:0]  tx_check_flags,
  output logic [15:0] tx_branch,
  output logic        tx_fault
);

  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(FETCH_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    word_op;
  logic [3:0]    word_check;
  logic [15:0]   word_branch;
  logic          wait_first;
  logic          unused_bits;

  assign cnt_next    = cnt + CW'(1);
  assign unused_bits = &{1'b0, rx_fetch_data[21:20]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      cnt             <= '0;
      word_op         <= '0;
      word_check      <= '0;
      word_branch     <= '0;
      wait_first      <= 1'b0;
      tx_fetch_req    <= 1'b0;
      tx_fetch_addr   <= '0;
      tx_enable       <= 1'b0;
      tx_write_branch <= 1'b0;
      tx_write_flags  <= 1'b0;
      tx_strobe       <= 1'b0;
      tx_input_flags  <= '0;
      tx_check_flags  <= '0;
      tx_branch       <= '0;
      tx_fault        <= 1'b0;
    end else begin
      tx_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_run) begin
            state         <= FETCH;
            tx_fetch_req  <= 1'b1;
            tx_fetch_addr <= RESET_PC;
            tx_enable     <= 1'b1;
            cnt           <= '0;
          end
        end

        // Abort beats valid, and valid beats the timeout in the same cycle.
        FETCH: begin
          if (!rx_run) begin
            state        <= IDLE;
            tx_fetch_req <= 1'b0;
            tx_enable    <= 1'b0;
          end else if (rx_fetch_valid) begin
            word_op      <= rx_fetch_data[23:22];
            word_check   <= rx_fetch_data[19:16];
            word_branch  <= rx_fetch_data[15:0];
            tx_fetch_req <= 1'b0;
            state        <= ISSUE;
          end else if (cnt_next == TIMEOUT_LIM) begin
            state        <= FAULT;
            tx_fetch_req <= 1'b0;
            tx_enable    <= 1'b0;
            tx_fault     <= 1'b1;
          end else begin
            cnt <= cnt_next;
          end
        end

        ISSUE: begin
          if (!rx_run) begin
            state     <= IDLE;
            tx_enable <= 1'b0;
          end else if (rx_ready) begin
            tx_strobe  <= 1'b1;
            state      <= WAIT;
            wait_first <= 1'b1;
            case (word_op)
              2'b01: begin
                tx_write_branch <= 1'b0;
                tx_write_flags  <= 1'b1;
                tx_input_flags  <= rx_alu_flags;
                tx_check_flags  <= '0;
                tx_branch       <= '0;
              end
              2'b10, 2'b11: begin
                tx_write_branch <= 1'b1;
                tx_write_flags  <= 1'b0;
                tx_input_flags  <= '0;
                tx_check_flags  <= word_op[0] ? 4'b0000 : word_check;
                tx_branch       <= word_branch;
              end
              default: begin
                tx_write_branch <= 1'b0;
                tx_write_flags  <= 1'b0;
                tx_input_flags  <= '0;
                tx_check_flags  <= '0;
                tx_branch       <= '0;
              end
            endcase
          end
        end

        // Ready in the strobe cycle is the brancher's stale status, so skip it.
        WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (rx_ready) begin
            if (rx_run) begin
              state         <= FETCH;
              tx_fetch_req  <= 1'b1;
              tx_fetch_addr <= rx_program_counter;
              cnt           <= '0;
            end else begin
              state     <= IDLE;
              tx_enable <= 1'b0;
            end
          end
        end

        FAULT: begin
          if (!rx_run) begin
            state    <= IDLE;
            tx_fault <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_issuer.sv
// Self-checking bench for branch_issuer: the bench plays instruction memory and brancher,
// and checks each command transaction against a decode model of the control word.
module tb_branch_issuer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        rx_run;
  logic [3:0]  rx_alu_flags;
  logic [15:0] rx_program_counter;
  logic        rx_ready;
  logic        rx_fetch_valid;
  logic [23:0] rx_fetch_data;
  logic        tx_fetch_req;
  logic [15:0] tx_fetch_addr;
  logic        tx_enable;
  logic        tx_write_branch;
  logic        tx_write_flags;
  logic        tx_strobe;
  logic [3:0]  tx_input_flags;
  logic [3:0]  tx_check_flags;
  logic [15:0] tx_branch;
  logic        tx_fault;

  int checks = 0;
  int errors = 0;

  branch_issuer #(.FETCH_TIMEOUT(16), .RESET_PC(16'h0000)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .rx_run             (rx_run),
    .rx_alu_flags       (rx_alu_flags),
    .rx_program_counter (rx_program_counter),
    .rx_ready           (rx_ready),
    .rx_fetch_valid     (rx_fetch_valid),
    .rx_fetch_data      (rx_fetch_data),
    .tx_fetch_req       (tx_fetch_req),
    .tx_fetch_addr      (tx_fetch_addr),
    .tx_enable          (tx_enable),
    .tx_write_branch    (tx_write_branch),
    .tx_write_flags     (tx_write_flags),
    .tx_strobe          (tx_strobe),
    .tx_input_flags     (tx_input_flags),
    .tx_check_flags     (tx_check_flags),
    .tx_branch          (tx_branch),
    .tx_fault           (tx_fault)
  );

  always #5 aclk = ~aclk;

  function automatic logic [45:0] all_outs();
    return {tx_fetch_req, tx_fetch_addr, tx_enable, tx_write_branch, tx_write_flags,
            tx_strobe, tx_input_flags, tx_check_flags, tx_branch, tx_fault};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One full command: fetch at addr (memory answers in lat cycles), brancher busy rdly
  // cycles before the issue, then busy bd cycles after the strobe before reporting pc_next.
  task automatic do_cmd(input logic [15:0] addr, input logic [23:0] wd, input int lat,
                        input int rdly, input int bd, input logic [15:0] pc_next,
                        input bit stay_run, input int alu_in);
    int n;
    int j;
    int j_req;
    bit bad;
    logic [3:0] alu_s;
    logic e_wb, e_wf;
    logic [3:0] e_in, e_chk;
    logic [15:0] e_br;

    n = 0;
    while (!tx_fetch_req && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (tx_fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_req_wait got %b want 1", tx_fetch_req);
      return;
    end
    checks++;
    if (tx_fetch_addr !== addr) begin
      errors++;
      $display("FAIL fetch_addr got %h want %h", tx_fetch_addr, addr);
    end

    bad = 0;
    for (int k = 1; k <= lat; k++) begin
      if (tx_fetch_req !== 1'b1 || tx_strobe !== 1'b0 || tx_fault !== 1'b0) bad = 1;
      rx_fetch_valid = (k == lat);
      rx_fetch_data  = (k == lat) ? wd : 24'($urandom);
      rx_ready       = 1'b0;
      tick();
    end
    rx_fetch_valid = 1'b0;
    checks++;
    if (bad || tx_fetch_req !== 1'b0 || tx_enable !== 1'b1) begin
      errors++;
      $display("FAIL fetch_phase req=%b en=%b bad=%0d want req 0 en 1", tx_fetch_req, tx_enable, bad);
    end

    bad = 0;
    alu_s = '0;
    for (int r = 0; r <= rdly; r++) begin
      if (tx_strobe !== 1'b0) bad = 1;
      rx_ready     = (r == rdly);
      rx_alu_flags = (alu_in < 0) ? 4'($urandom) : 4'(alu_in);
      if (r == rdly) alu_s = rx_alu_flags;
      tick();
    end

    e_wb = 0; e_wf = 0; e_in = '0; e_chk = '0; e_br = '0;
    case (wd[23:22])
      2'd1: begin e_wf = 1; e_in = alu_s; end
      2'd2: begin e_wb = 1; e_chk = wd[19:16]; e_br = wd[15:0]; end
      2'd3: begin e_wb = 1; e_chk = 4'h0; e_br = wd[15:0]; end
      default: ;
    endcase

    checks++;
    if (bad || tx_strobe !== 1'b1 || tx_fault !== 1'b0) begin
      errors++;
      $display("FAIL strobe got %b early=%0d fault=%b want 1", tx_strobe, bad, tx_fault);
    end
    checks++;
    if (tx_write_branch !== e_wb || tx_write_flags !== e_wf) begin
      errors++;
      $display("FAIL selects word %h got wb=%b wf=%b want wb=%b wf=%b", wd,
               tx_write_branch, tx_write_flags, e_wb, e_wf);
    end
    if (e_wf) begin
      checks++;
      if (tx_input_flags !== e_in) begin
        errors++;
        $display("FAIL input_flags got %h want %h", tx_input_flags, e_in);
      end
    end
    if (e_wb) begin
      checks++;
      if (tx_check_flags !== e_chk || tx_branch !== e_br) begin
        errors++;
        $display("FAIL branch_fields got chk=%h br=%h want chk=%h br=%h",
                 tx_check_flags, tx_branch, e_chk, e_br);
      end
    end

    rx_program_counter = pc_next;
    rx_ready = (bd == 0);
    if (!stay_run) rx_run = 1'b0;
    tick();
    checks++;
    if (tx_strobe !== 1'b0 || tx_fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL after_strobe got strobe=%b req=%b want 0 0", tx_strobe, tx_fetch_req);
    end

    j_req = ((bd + 1 > 2) ? bd + 1 : 2) + 1;
    bad = 0;
    j = 2;
    while (j < j_req + 4 && !(stay_run && tx_fetch_req)) begin
      if (tx_strobe !== 1'b0 || tx_fetch_req !== 1'b0) bad = 1;
      rx_ready = (j >= bd + 1);
      tick();
      j++;
    end
    if (stay_run) begin
      checks++;
      if (j !== j_req || tx_fetch_req !== 1'b1 || bad) begin
        errors++;
        $display("FAIL next_fetch_latency got %0d req=%b want %0d req 1", j, tx_fetch_req, j_req);
      end
      checks++;
      if (tx_fetch_addr !== pc_next || tx_write_branch !== e_wb) begin
        errors++;
        $display("FAIL next_addr got %h wb=%b want %h wb=%b", tx_fetch_addr, tx_write_branch,
                 pc_next, e_wb);
      end
    end else begin
      checks++;
      if (bad || tx_enable !== 1'b0) begin
        errors++;
        $display("FAIL stop_after_wait en=%b stray=%0d want en 0 stray 0", tx_enable, bad);
      end
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!tx_fetch_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (tx_fetch_req !== 1'b1 || tx_fetch_addr !== 16'h0000) begin
      errors++;
      $display("FAIL %s req=%b addr=%h want req 1 addr 0000", name, tx_fetch_req, tx_fetch_addr);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; rx_run = 0; rx_alu_flags = '0; rx_program_counter = '0;
    rx_ready = 0; rx_fetch_valid = 0; rx_fetch_data = '0;
    #12;
    checks++;
    if (all_outs() !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    aresetn = 1'b1;
    tick();
    tick();
    checks++;
    if (all_outs() !== 46'd0) begin
      errors++;
      $display("FAIL idle_outputs got %h want 0", all_outs());
    end
  endtask

  task automatic test_directed();
    rx_run = 1'b1;
    do_cmd(16'h0000, 24'h000000, 3, 0, 0, 16'h0001, 1, -1);
    do_cmd(16'h0001, 24'h8A1234, 2, 1, 2, 16'h1234, 1, -1);
    do_cmd(16'h1234, 24'h400000, 1, 2, 1, 16'h1235, 1, 5);
    do_cmd(16'h1235, 24'hCF00FF, 1, 0, 3, 16'h00FF, 0, -1);
  endtask

  task automatic test_back_to_back();
    rx_run = 1'b1;
    do_cmd(16'h0000, 24'h800010, 1, 0, 0, 16'h0010, 1, -1);
    do_cmd(16'h0010, 24'h400000, 1, 0, 0, 16'h0011, 1, -1);
    do_cmd(16'h0011, 24'h000000, 1, 0, 0, 16'h0012, 0, -1);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] nx;
    a = 16'h0000;
    rx_run = 1'b1;
    for (int i = 0; i < 25; i++) begin
      nx = 16'($urandom);
      do_cmd(a, 24'($urandom), $urandom_range(1, 16), $urandom_range(0, 3),
             $urandom_range(0, 4), nx, i != 24, -1);
      a = nx;
    end
  endtask

  task automatic test_timeout();
    bit bad;
    rx_run = 1'b1;
    rx_ready = 1'b1;
    wait_req("timeout_start");
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      if (tx_fault !== 1'b0 || tx_fetch_req !== 1'b1) bad = 1;
      tick();
    end
    checks++;
    if (bad || tx_fault !== 1'b1 || tx_enable !== 1'b0 || tx_fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault fault=%b en=%b req=%b early=%0d want 1 0 0 0",
               tx_fault, tx_enable, tx_fetch_req, bad);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      rx_fetch_valid = 1'b1;
      rx_fetch_data  = 24'h000000;
      tick();
      if (tx_fault !== 1'b1 || tx_strobe !== 1'b0 || tx_enable !== 1'b0) bad = 1;
    end
    rx_fetch_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fault_sticky got unstable fault state want fault held, no strobe");
    end
    rx_run = 1'b0;
    tick();
    checks++;
    if (tx_fault !== 1'b0 || tx_enable !== 1'b0 || tx_fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear fault=%b en=%b req=%b want 0 0 0", tx_fault, tx_enable, tx_fetch_req);
    end
    tick();
    rx_run = 1'b1;
    do_cmd(16'h0000, 24'h8A0042, 16, 0, 0, 16'h0042, 0, -1);
  endtask

  task automatic test_abort_fetch();
    bit bad;
    rx_run = 1'b1;
    rx_ready = 1'b1;
    wait_req("abort_fetch_start");
    tick();
    tick();
    rx_run = 1'b0;
    tick();
    checks++;
    if (tx_fetch_req !== 1'b0 || tx_enable !== 1'b0) begin
      errors++;
      $display("FAIL abort_fetch req=%b en=%b want 0 0", tx_fetch_req, tx_enable);
    end
    rx_fetch_valid = 1'b1;
    rx_fetch_data  = 24'hC01234;
    tick();
    rx_fetch_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (tx_strobe !== 1'b0 || tx_fetch_req !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL late_valid got activity after abort want none");
    end
    rx_run = 1'b1;
    do_cmd(16'h0000, 24'h400000, 2, 0, 1, 16'h0001, 0, 9);
  endtask

  task automatic test_abort_issue();
    bit bad;
    rx_run = 1'b1;
    rx_ready = 1'b0;
    wait_req("abort_issue_start");
    rx_fetch_valid = 1'b1;
    rx_fetch_data  = 24'h8F5555;
    tick();
    rx_fetch_valid = 1'b0;
    tick();
    rx_run = 1'b0;
    tick();
    rx_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (tx_strobe !== 1'b0 || tx_enable !== 1'b0 || tx_fetch_req !== 1'b0) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_issue got strobe/enable activity want none");
    end
    rx_run = 1'b1;
    do_cmd(16'h0000, 24'h000000, 1, 0, 0, 16'h0001, 0, -1);
  endtask

  task automatic test_async_reset();
    rx_run = 1'b1;
    rx_ready = 1'b0;
    wait_req("async_reset_start");
    rx_fetch_valid = 1'b1;
    rx_fetch_data  = 24'hCF00FF;
    tick();
    rx_fetch_valid = 1'b0;
    rx_ready = 1'b1;
    tick();
    checks++;
    if (tx_strobe !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_strobe got %b want 1", tx_strobe);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 46'd0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", all_outs());
    end
    aresetn = 1'b1;
    do_cmd(16'h0000, 24'h8A1234, 3, 0, 0, 16'h1234, 0, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_timeout();
    test_abort_fetch();
    test_abort_issue();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
